prog_mem: RTL and testbench

Parametrised synchronous program memory for the teaching CPU: it replaces the fixed combinational instruction ROM. After reset it self-initialises with the built-in multiply demo image. A valid/ready load port can stream a new program in at run time. The CPU fetch stage reads it through a one-cycle registered read port with a valid flag.

---
 rtl/prog_mem_pkg.sv | 30 +++
 rtl/prog_mem_if.sv | 33 +++
 rtl/prog_mem_ram.sv | 30 +++
 rtl/prog_mem.sv | 140 ++++++++++++++
 tb/tb_prog_mem.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared types and constants for the program memory.
//   state_t        FSM encoding (INIT, IDLE, LOAD)
//   DEFAULT_LEN    number of words in the built-in demo image
//   DEFAULT_IMAGE  multiply demo program loaded by INIT
//   default_word() image word for an address, zero beyond the image
package prog_mem_pkg;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      LOAD = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_LEN = 8;
   localparam int unsigned DEFAULT_IW  = $clog2(DEFAULT_LEN);

   localparam logic [7:0] DEFAULT_IMAGE [DEFAULT_LEN] = '{
      8'h01, 8'h02, 8'h05, 8'h22, 8'h01, 8'h03, 8'h0a, 8'h22
   };

   function automatic logic [7:0] default_word(input int unsigned idx);
      logic [DEFAULT_IW-1:0] i;
      i = idx[DEFAULT_IW-1:0];
      if (idx < DEFAULT_LEN) begin
         return DEFAULT_IMAGE[i];
      end
      return 8'h00;
   endfunction

endpackage

// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch read port and program load port of prog_mem.
//   adrs/rd            -> read request
//   dout/dvalid/rd_err <- registered read response
//   ld_start/ld_data/ld_valid/ld_last -> load session and word stream
//   ld_ready/ld_count/busy            <- load status
// master: CPU / loader side, slave: memory side.
interface prog_mem_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic [AW-1:0] adrs;
   logic          rd;
   logic [DW-1:0] dout;
   logic          dvalid;
   logic          rd_err;
   logic          ld_start;
   logic [DW-1:0] ld_data;
   logic          ld_valid;
   logic          ld_last;
   logic          ld_ready;
   logic [AW:0]   ld_count;
   logic          busy;

   modport master (
      output adrs, rd, ld_start, ld_data, ld_valid, ld_last,
      input  dout, dvalid, rd_err, ld_ready, ld_count, busy
   );

   modport slave (
      input  adrs, rd, ld_start, ld_data, ld_valid, ld_last,
      output dout, dvalid, rd_err, ld_ready, ld_count, busy
   );
endinterface

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: DW x DEPTH storage array, no reset.
//   clk         clock
//   we/waddr/wdata  synchronous write port
//   re/raddr/q      registered read port, q only updates when re=1
module prog_mem_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 256,
   parameter int IW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [IW-1:0] raddr,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         q <= mem[raddr];
      end
   end

endmodule

// File: rtl/prog_mem.sv
// prog_mem: synchronous program memory with self-initialisation and a
// run-time load port.
//   clk  clock
//   rst  synchronous active-high reset
//   bus  prog_mem_if slave: read port (adrs, rd, dout, dvalid, rd_err)
//        and load port (ld_start, ld_data, ld_valid, ld_last, ld_ready,
//        ld_count, busy)
//
// state | meaning
// INIT  | writes the default image (zeros past it), one word per cycle
// IDLE  | reads accepted, ld_start opens a load session
// LOAD  | streams words in from wptr 0 until ld_last or the last address
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int DW    = 8,
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic     clk,
   input  logic     rst,
   prog_mem_if.slave bus
);

   localparam int            IW      = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

   state_t        state, state_nxt;
   logic [IW-1:0] iptr;
   logic [IW-1:0] wptr;
   logic [AW:0]   ld_count;
   logic          rd_acc;
   logic          rd_oob;
   logic          ld_acc;
   logic          we;
   logic [IW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] ram_q;
   logic          dvalid_r;
   logic          rd_err_r;
   logic          dout_zero;

   assign rd_acc = (state == IDLE) && bus.rd;
   assign rd_oob = {1'b0, bus.adrs} >= DEPTH_W;
   assign ld_acc = (state == LOAD) && bus.ld_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT: if (iptr == LAST) state_nxt = IDLE;
         IDLE: if (bus.ld_start) state_nxt = LOAD;
         LOAD: if (ld_acc && (bus.ld_last || wptr == LAST)) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iptr     <= '0;
         wptr     <= '0;
         ld_count <= '0;
      end else begin
         if (state == INIT) begin
            iptr <= iptr + 1'b1;
         end
         if ((state == IDLE) && bus.ld_start) begin
            wptr     <= '0;
            ld_count <= '0;
         end else if (ld_acc) begin
            wptr     <= wptr + 1'b1;
            ld_count <= ld_count + 1'b1;
         end
      end
   end

   // Writes are blocked while rst is high so an aborted load cannot land a
   // stray word on the reset edge.
   always_comb begin
      we    = 1'b0;
      waddr = wptr;
      wdata = bus.ld_data;
      if (!rst) begin
         if (state == INIT) begin
            we    = 1'b1;
            waddr = iptr;
            wdata = DW'(default_word(32'(iptr)));
         end else if (ld_acc) begin
            we = 1'b1;
         end
      end
   end

   prog_mem_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (rd_acc && !rd_oob),
      .raddr (bus.adrs[IW-1:0]),
      .q     (ram_q)
   );

   // The array has no reset, so dout is forced to zero until the first
   // in-range read; an out-of-range read also sets it back to zero, and
   // ram_q keeps the last good word because its enable stays low meanwhile.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvalid_r  <= 1'b0;
         rd_err_r  <= 1'b0;
         dout_zero <= 1'b1;
      end else begin
         dvalid_r <= rd_acc;
         rd_err_r <= rd_acc && rd_oob;
         if (rd_acc) begin
            dout_zero <= rd_oob;
         end
      end
   end

   assign bus.dout     = dout_zero ? '0 : ram_q;
   assign bus.dvalid   = dvalid_r;
   assign bus.rd_err   = rd_err_r;
   assign bus.ld_ready = (state == LOAD);
   assign bus.busy     = (state != IDLE);
   assign bus.ld_count = ld_count;

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

   localparam int DW      = 8;
   localparam int AW_M    = 8;
   localparam int DEPTH_M = 256;
   localparam int AW_S    = 5;
   localparam int DEPTH_S = 16;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_m;
   logic rst_s;

   always #5 clk = ~clk;

   prog_mem_if #(.DW(DW), .AW(AW_M)) bm ();
   prog_mem_if #(.DW(DW), .AW(AW_S)) bs ();

   prog_mem #(.DW(DW), .AW(AW_M), .DEPTH(DEPTH_M)) dut_m (
      .clk (clk),
      .rst (rst_m),
      .bus (bm)
   );

   prog_mem #(.DW(DW), .AW(AW_S), .DEPTH(DEPTH_S)) dut_s (
      .clk (clk),
      .rst (rst_s),
      .bus (bs)
   );

   logic [7:0]    img [8] = '{8'h01, 8'h02, 8'h05, 8'h22, 8'h01, 8'h03, 8'h0a, 8'h22};
   logic [DW-1:0] ref_m [DEPTH_M];
   logic [DW-1:0] ref_s [DEPTH_S];
   exp_t          qm [$];
   exp_t          qs [$];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      exp_t e;
      if (bm.dvalid === 1'b1) begin
         if (qm.size() == 0) begin
            chk("m_unexpected_dvalid", {31'd0, bm.dvalid}, 32'd0);
         end else begin
            e = qm.pop_front();
            chk("m_dout", 32'(bm.dout), 32'(e.d));
            chk("m_rd_err", {31'd0, bm.rd_err}, {31'd0, e.e});
         end
      end else if (bm.rd_err === 1'b1) begin
         chk("m_rd_err_without_dvalid", {31'd0, bm.rd_err}, 32'd0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bs.dvalid === 1'b1) begin
         if (qs.size() == 0) begin
            chk("s_unexpected_dvalid", {31'd0, bs.dvalid}, 32'd0);
         end else begin
            e = qs.pop_front();
            chk("s_dout", 32'(bs.dout), 32'(e.d));
            chk("s_rd_err", {31'd0, bs.rd_err}, {31'd0, e.e});
         end
      end else if (bs.rd_err === 1'b1) begin
         chk("s_rd_err_without_dvalid", {31'd0, bs.rd_err}, 32'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- large instance helpers ----------------
   task automatic reset_m();
      int cyc;
      @(negedge clk);
      rst_m = 1'b1;
      bm.rd = 1'b0; bm.adrs = '0; bm.ld_start = 1'b0;
      bm.ld_valid = 1'b0; bm.ld_last = 1'b0; bm.ld_data = '0;
      @(negedge clk);
      chk("m_rst_busy", {31'd0, bm.busy}, 32'd1);
      chk("m_rst_dout", 32'(bm.dout), 32'd0);
      chk("m_rst_dvalid", {31'd0, bm.dvalid}, 32'd0);
      chk("m_rst_rd_err", {31'd0, bm.rd_err}, 32'd0);
      chk("m_rst_ld_ready", {31'd0, bm.ld_ready}, 32'd0);
      chk("m_rst_ld_count", 32'(bm.ld_count), 32'd0);
      rst_m = 1'b0;
      for (int i = 0; i < DEPTH_M; i++) ref_m[i] = (i < 8) ? img[i] : '0;
      cyc = 0;
      while (bm.busy === 1'b1 && cyc < 2 * DEPTH_M) begin
         @(negedge clk);
         cyc++;
         bm.rd   = (cyc == 2);  // sampled on edge 3 of INIT, must be dropped
         bm.adrs = '0;
      end
      bm.rd = 1'b0;
      chk("m_init_len", 32'(cyc), 32'(DEPTH_M));
      chk("m_init_dout", 32'(bm.dout), 32'd0);
   endtask

   task automatic rd_m(input int a);
      exp_t e;
      @(negedge clk);
      bm.rd   = 1'b1;
      bm.adrs = AW_M'(a);
      e.d = ref_m[a];
      e.e = 1'b0;
      qm.push_back(e);
   endtask

   task automatic rd_end_m();
      @(negedge clk);
      bm.rd = 1'b0;
   endtask

   task automatic drain_m();
      repeat (2) @(negedge clk);
      chk("m_sb_drain", 32'(qm.size()), 32'd0);
   endtask

   task automatic load_m(input logic [DW-1:0] w[$], input int gap_at,
                         input bit rd_with_start, input int rd_a);
      int   n;
      exp_t e;
      n = w.size();
      @(negedge clk);
      bm.ld_start = 1'b1;
      if (rd_with_start) begin
         bm.rd   = 1'b1;
         bm.adrs = AW_M'(rd_a);
         e.d = ref_m[rd_a];
         e.e = 1'b0;
         qm.push_back(e);
      end
      @(negedge clk);
      bm.ld_start = 1'b0;
      bm.rd       = 1'b0;
      chk("m_ld_ready_rise", {31'd0, bm.ld_ready}, 32'd1);
      chk("m_busy_in_load", {31'd0, bm.busy}, 32'd1);
      chk("m_ld_count_clear", 32'(bm.ld_count), 32'd0);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at || (gap_at < 0 && $urandom_range(0, 3) == 0)) begin
            bm.ld_valid = 1'b0;
            bm.ld_start = 1'b0;
            bm.rd       = 1'b1;  // reads in LOAD are dropped
            bm.adrs     = AW_M'($urandom_range(0, DEPTH_M - 1));
            @(negedge clk);
            bm.rd = 1'b0;
         end
         bm.ld_valid = 1'b1;
         bm.ld_data  = w[i];
         bm.ld_last  = (i == n - 1);
         bm.ld_start = (i == 1);  // ignored in LOAD
         @(negedge clk);
      end
      bm.ld_valid = 1'b0;
      bm.ld_last  = 1'b0;
      bm.ld_start = 1'b0;
      chk("m_ld_ready_fall", {31'd0, bm.ld_ready}, 32'd0);
      chk("m_busy_after_load", {31'd0, bm.busy}, 32'd0);
      chk("m_ld_count", 32'(bm.ld_count), 32'(n));
      for (int i = 0; i < n; i++) ref_m[i] = w[i];
   endtask

   // ---------------- small instance helpers ----------------
   task automatic rd_s(input int a);
      exp_t e;
      @(negedge clk);
      bs.rd   = 1'b1;
      bs.adrs = AW_S'(a);
      if (a < DEPTH_S) begin
         e.d = ref_s[a];
         e.e = 1'b0;
      end else begin
         e.d = '0;
         e.e = 1'b1;
      end
      qs.push_back(e);
   endtask

   task automatic rd_end_s();
      @(negedge clk);
      bs.rd = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] w[$];
      int            cyc;
      int            a;

      rst_s = 1'b1;
      bs.rd = 1'b0; bs.adrs = '0; bs.ld_start = 1'b0;
      bs.ld_valid = 1'b0; bs.ld_last = 1'b0; bs.ld_data = '0;
      rst_m = 1'b1;

      // reset, INIT length, dropped read during INIT, default image
      reset_m();
      for (int i = 0; i <= 8; i++) rd_m(i);
      rd_end_m();
      drain_m();

      // short load with ld_last and a valid gap, then read back
      w = '{8'h3C, 8'h4D, 8'h5E};
      load_m(w, 2, 1'b0, 0);
      for (int i = 0; i < 4; i++) rd_m(i);
      rd_end_m();
      drain_m();
      chk("m_dout_hold", 32'(bm.dout), 32'h22);
      chk("m_ld_count_hold", 32'(bm.ld_count), 32'd3);

      // reset in the middle of a load session
      @(negedge clk); bm.ld_start = 1'b1;
      @(negedge clk); bm.ld_start = 1'b0; bm.ld_valid = 1'b1; bm.ld_data = 8'hAA;
      @(negedge clk); bm.ld_data = 8'hBB;
      @(negedge clk); bm.ld_valid = 1'b0;
      chk("m_partial_count", 32'(bm.ld_count), 32'd2);
      reset_m();
      rd_m(0);
      rd_m(1);
      rd_end_m();
      drain_m();
      chk("m_count_after_abort", 32'(bm.ld_count), 32'd0);

      // read and ld_start in the same IDLE cycle
      w = '{8'h77, 8'h88};
      load_m(w, -2, 1'b1, 2);
      drain_m();

      // randomized loads and reads
      repeat (6) begin
         w.delete();
         repeat ($urandom_range(1, 10)) w.push_back(DW'($urandom));
         load_m(w, -1, 1'b0, 0);
         repeat (12) begin
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH_M - 1);
            rd_m(a);
            if ($urandom_range(0, 2) == 0) rd_end_m();
         end
         rd_end_m();
         drain_m();
      end

      // small instance: INIT length, auto-close load, out-of-range reads
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 0; i < DEPTH_S; i++) ref_s[i] = (i < 8) ? img[i] : '0;
      cyc = 0;
      while (bs.busy === 1'b1 && cyc < 4 * DEPTH_S) begin
         @(negedge clk);
         cyc++;
      end
      chk("s_init_len", 32'(cyc), 32'(DEPTH_S));

      @(negedge clk); bs.ld_start = 1'b1;
      @(negedge clk); bs.ld_start = 1'b0;
      chk("s_ld_ready_rise", {31'd0, bs.ld_ready}, 32'd1);
      for (int i = 0; i < DEPTH_S; i++) begin
         ref_s[i]    = DW'($urandom_range(1, 254));
         bs.ld_valid = 1'b1;
         bs.ld_last  = 1'b0;
         bs.ld_data  = ref_s[i];
         @(negedge clk);
      end
      // one extra word after auto-close must be ignored
      bs.ld_data = 8'hFF;
      chk("s_autoclose_ready", {31'd0, bs.ld_ready}, 32'd0);
      chk("s_autoclose_busy", {31'd0, bs.busy}, 32'd0);
      chk("s_autoclose_count", 32'(bs.ld_count), 32'(DEPTH_S));
      @(negedge clk);
      bs.ld_valid = 1'b0;

      rd_s(20);
      rd_end_s();
      @(negedge clk);
      chk("s_oob_dout_hold", 32'(bs.dout), 32'd0);
      for (int i = 0; i < DEPTH_S; i++) rd_s(i);
      rd_s(16);
      rd_s(5);
      rd_s(31);
      rd_end_s();
      repeat (20) begin
         rd_s($urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0) rd_end_s();
      end
      rd_end_s();
      repeat (2) @(negedge clk);
      chk("s_sb_drain", 32'(qs.size()), 32'd0);
      chk("s_ld_count_hold", 32'(bs.ld_count), 32'(DEPTH_S));

      chk("m_sb_final", 32'(qm.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
